// File: rtl/manchester_decoder.sv
// -----------------------------------------------------------------------------
// manchester_decoder
//   Recovers bytes from a serial Manchester stream that arrives one half-bit
//   per clock, LSB of each byte first. Supports the IEEE convention (first
//   half-bit equals the data bit) and the Thomas convention (first half-bit is
//   the inverted data bit). An illegal half-bit pair (both halves equal) is
//   reported, counted, and used to slip alignment by one half-bit.
//
// Ports
//   clk          in   1  clock, all state updates on the rising edge
//   rst_n        in   1  asynchronous active-low reset
//   encode_mode  in   1  0 = IEEE, 1 = Thomas; latched at the start of a byte
//   line_in      in   1  serial Manchester half-bit stream
//   data_out     out  8  last fully decoded byte, held between pulses
//   data_valid   out  1  one-cycle pulse marking a new data_out
//   code_err     out  1  one-cycle pulse on an illegal half-bit pair
//   locked       out  1  high while half-bit and byte alignment is held
//   err_count    out  8  saturating count of code_err pulses since reset
// -----------------------------------------------------------------------------
module manchester_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       encode_mode,
    input  logic       line_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       code_err,
    output logic       locked,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        h1_r;
    logic        mode_r;
    logic [2:0]  bit_cnt_r;
    logic [7:0]  shift_r;
    logic        pair_err_s;
    logic        bit_s;
    logic [7:0]  assembled_s;

    // Saturating increment so the error counter sticks at its maximum.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            sat_inc8 = 8'hFF;
        end else begin
            sat_inc8 = value + 8'd1;
        end
    endfunction

    // Next-state decode and pair check; line_in only reaches registers.
    always_comb begin
        state_next_s = state_r;
        pair_err_s   = 1'b0;
        // Mode 0 decodes as h1, mode 1 as ~h1.
        bit_s        = h1_r ^ mode_r;
        assembled_s  = shift_r;
        assembled_s[bit_cnt_r] = bit_s;
        case (state_r)
            ST_START: begin
                state_next_s = ST_FIRST;
            end
            ST_FIRST: begin
                state_next_s = ST_SECOND;
            end
            ST_SECOND: begin
                if (h1_r == line_in) begin
                    pair_err_s   = 1'b1;
                    // The offending h2 becomes h1 of the next pair.
                    state_next_s = ST_SECOND;
                end else begin
                    state_next_s = ST_FIRST;
                end
            end
            default: begin
                state_next_s = ST_START;
            end
        endcase
    end

    // State register, byte assembly and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_START;
            h1_r       <= 1'b0;
            mode_r     <= 1'b0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            code_err   <= 1'b0;
            locked     <= 1'b0;
            err_count  <= 8'h00;
        end else begin
            state_r    <= state_next_s;
            data_valid <= 1'b0;
            code_err   <= 1'b0;
            case (state_r)
                ST_START: begin
                    // The upstream register's reset value is discarded here.
                    h1_r <= 1'b0;
                end
                ST_FIRST: begin
                    h1_r <= line_in;
                    if (bit_cnt_r == 3'd0) begin
                        mode_r <= encode_mode;
                    end else begin
                        mode_r <= mode_r;
                    end
                end
                ST_SECOND: begin
                    if (pair_err_s) begin
                        code_err  <= 1'b1;
                        err_count <= sat_inc8(err_count);
                        locked    <= 1'b0;
                        bit_cnt_r <= 3'd0;
                        shift_r   <= 8'h00;
                        h1_r      <= line_in;
                        // The slip skips FIRST, so the new byte's mode is
                        // latched here alongside its first h1.
                        mode_r    <= encode_mode;
                    end else begin
                        shift_r   <= assembled_s;
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            data_out   <= assembled_s;
                            data_valid <= 1'b1;
                            locked     <= 1'b1;
                        end else begin
                            data_out   <= data_out;
                        end
                    end
                end
                default: begin
                    h1_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_manchester_decoder.sv
// -----------------------------------------------------------------------------
// tb_manchester_decoder
//   Table-driven bench: a list of {mode, byte} records is Manchester-encoded by
//   the bench and fed to the decoder; each byte's output is compared with the
//   record. Hand-written sequences cover illegal pairs, mid-byte mode change,
//   asynchronous reset mid-byte and error-counter saturation.
// -----------------------------------------------------------------------------
module tb_manchester_decoder;

    logic       clk;
    logic       rst_n;
    logic       encode_mode;
    logic       line_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       code_err;
    logic       locked;
    logic [7:0] err_count;

    int n_vec;
    int n_err;

    typedef struct {
        logic       mode;
        logic [7:0] data;
        logic [7:0] exp_err;
    } vec_t;

    vec_t vecs[8];

    manchester_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .encode_mode (encode_mode),
        .line_in     (line_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .code_err    (code_err),
        .locked      (locked),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data_out"},   data_out,          8'h00);
        check({tag, "_data_valid"}, {7'd0, data_valid}, 8'h00);
        check({tag, "_code_err"},   {7'd0, code_err},   8'h00);
        check({tag, "_locked"},     {7'd0, locked},     8'h00);
        check({tag, "_err_count"},  err_count,         8'h00);
    endtask

    // Release reset at a falling edge and let the decoder discard one sample.
    task automatic start_stream();
        rst_n   = 1'b1;
        line_in = 1'b0;
        @(negedge clk);
    endtask

    // Drive half-bits first_idx..15 of a byte; returns at the falling edge
    // after the last half-bit has been sampled. toggle_at flips encode_mode
    // just before that half-bit index (-1 = never).
    task automatic send_halves(input logic mode, input logic [7:0] data,
                               input int first_idx, input int toggle_at);
        logic mid_bad;
        logic d;
        logic [7:0] dbyte;
        mid_bad = 1'b0;
        dbyte   = data;
        for (int i = first_idx; i < 16; i++) begin
            d = dbyte[i / 2];
            if ((i % 2) == 0) begin
                line_in = d ^ mode;
            end else begin
                line_in = ~(d ^ mode);
            end
            if (i == toggle_at) begin
                encode_mode = ~encode_mode;
            end
            @(negedge clk);
            if (i != 15 && (data_valid || code_err)) begin
                mid_bad = 1'b1;
            end
        end
        check("mid_byte_quiet", {7'd0, mid_bad}, 8'h00);
    endtask

    task automatic check_byte(input string tag, input logic [7:0] exp_data,
                              input logic [7:0] exp_err);
        check({tag, "_valid"},  {7'd0, data_valid}, 8'h01);
        check({tag, "_data"},   data_out,          exp_data);
        check({tag, "_noerr"},  {7'd0, code_err},   8'h00);
        check({tag, "_locked"}, {7'd0, locked},     8'h01);
        check({tag, "_errcnt"}, err_count,         exp_err);
    endtask

    initial begin
        logic dv_seen;
        n_vec = 0;
        n_err = 0;

        vecs[0] = '{1'b0, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 8'hA5, 8'h00};
        vecs[2] = '{1'b0, 8'h00, 8'h00};
        vecs[3] = '{1'b0, 8'hFF, 8'h00};
        vecs[4] = '{1'b1, 8'h3C, 8'h00};
        vecs[5] = '{1'b1, 8'h3C, 8'h00};
        vecs[6] = '{1'b1, 8'hC3, 8'h00};
        vecs[7] = '{1'b0, 8'h5A, 8'h00};

        rst_n       = 1'b0;
        line_in     = 1'b0;
        encode_mode = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");

        // Main table: back-to-back bytes, one byte every 16 cycles.
        start_stream();
        for (int v = 0; v < 8; v++) begin
            encode_mode = vecs[v].mode;
            send_halves(vecs[v].mode, vecs[v].data, 0, -1);
            check_byte("table", vecs[v].data, vecs[v].exp_err);
        end

        // Illegal pair 1,1 at bit 3 of a byte.
        encode_mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            line_in = (i % 2 == 0) ? 1'b1 : 1'b0;  // bits 0..2 of 8'h0F
            @(negedge clk);
        end
        line_in = 1'b1;
        @(negedge clk);
        line_in = 1'b1;
        @(negedge clk);
        check("err_pulse",  {7'd0, code_err},   8'h01);
        check("err_count1", err_count,         8'h01);
        check("err_unlock", {7'd0, locked},     8'h00);
        check("err_no_dv",  {7'd0, data_valid}, 8'h00);
        // The second '1' is now h1; a following '0' completes bit 0 = 1.
        send_halves(1'b0, 8'h5B, 1, -1);
        check_byte("relock", 8'h5B, 8'h01);

        // Mode flips at bit 4: this byte stays IEEE, the next one is Thomas.
        encode_mode = 1'b0;
        send_halves(1'b0, 8'h96, 0, 8);
        check_byte("mode_hold", 8'h96, 8'h01);
        send_halves(1'b1, 8'h69, 0, -1);
        check_byte("mode_next", 8'h69, 8'h01);

        // Asynchronous reset in the middle of a byte.
        encode_mode = 1'b0;
        for (int i = 0; i < 7; i++) begin
            line_in = (i % 2 == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("rst_hold");
        start_stream();
        send_halves(1'b0, 8'hC7, 0, -1);
        check_byte("post_rst", 8'hC7, 8'h00);

        // Constant-zero line: an error every cycle once the first pair fails.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        start_stream();
        dv_seen = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (data_valid) dv_seen = 1'b1;
            if (k == 1)   check("sat_k1",   err_count, 8'h00);
            if (k == 2)   check("sat_k2",   err_count, 8'h01);
            if (k == 255) check("sat_k255", err_count, 8'hFE);
            if (k == 256) check("sat_k256", err_count, 8'hFF);
            if (k == 600) check("sat_k600", err_count, 8'hFF);
        end
        check("sat_no_dv",  {7'd0, dv_seen}, 8'h00);
        check("sat_locked", {7'd0, locked},  8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
